// File: rtl/snowflake_sysctl_pkg.sv
// snowflake_sysctl_pkg: register offsets and field widths for the snowflake system-control block
package snowflake_sysctl_pkg;
  localparam logic [5:0] SYSCTL_LED        = 6'h00;
  localparam logic [5:0] SYSCTL_BLINK      = 6'h01;
  localparam logic [5:0] SYSCTL_BLINK_DIV  = 6'h02;
  localparam logic [5:0] SYSCTL_SSD_CTRL   = 6'h03;
  localparam logic [5:0] SYSCTL_SSD_DIV    = 6'h04;
  localparam logic [5:0] SYSCTL_CYCLE      = 6'h05;
  localparam logic [5:0] SYSCTL_DIGIT_BASE = 6'h08;
  localparam int WORD_W      = 32;
  localparam int BLINK_DIV_W = 24;
  localparam int SSD_DIV_W   = 16;
  localparam int SEG_W       = 7;
endpackage

// File: rtl/snowflake_ssd_scan.sv
// snowflake_ssd_scan: multiplexed 7-segment scan engine with programmable per-digit period
module snowflake_ssd_scan
  import snowflake_sysctl_pkg::*;
#(
  parameter int NUM_DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [SSD_DIV_W-1:0]  div,
  input  logic [SEG_W-1:0]      digits [NUM_DIGITS],
  output logic [SEG_W-1:0]      seg,
  output logic [NUM_DIGITS-1:0] sel
);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  logic [SSD_DIV_W-1:0] cnt_q;
  logic [IW-1:0]        idx_q;
  logic                 wrap;
  assign wrap = cnt_q >= div;
  // disabled scan is held at digit 0 with a fresh count so re-enable starts a full period
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt_q <= '0;
      idx_q <= '0;
      seg   <= '0;
      sel   <= '0;
    end else begin
      cnt_q <= wrap ? '0 : cnt_q + 1'b1;
      if (wrap) idx_q <= idx_q == IW'(NUM_DIGITS - 1) ? '0 : idx_q + 1'b1;
      sel   <= NUM_DIGITS'(1) << idx_q;
      seg   <= digits[idx_q];
    end
  end
endmodule

// File: rtl/snowflake_sysctl.sv
// snowflake_sysctl: register file with LED blink, 7-segment scan and free-running cycle counter
module snowflake_sysctl
  import snowflake_sysctl_pkg::*;
#(
  parameter int                     NUM_LEDS      = 2,
  parameter int                     NUM_DIGITS    = 2,
  parameter logic [SSD_DIV_W-1:0]   SCAN_DIV_RST  = 16'd11999,
  parameter logic [BLINK_DIV_W-1:0] BLINK_DIV_RST = 24'd11999999
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WORD_W-1:0]     sys_addr,
  input  logic [WORD_W-1:0]     sys_wr_data,
  input  logic                  sys_en,
  input  logic                  sys_wr_en,
  output logic [WORD_W-1:0]     sys_rd_data,
  output logic [NUM_LEDS-1:0]   led,
  output logic [SEG_W-1:0]      ssd_seg,
  output logic [NUM_DIGITS-1:0] ssd_sel
);
  logic [NUM_LEDS-1:0]    led_q, blink_q;
  logic [BLINK_DIV_W-1:0] blink_div_q, blink_cnt_q;
  logic [SSD_DIV_W-1:0]   ssd_div_q;
  logic [WORD_W-1:0]      cycle_q, rd_d;
  logic [SEG_W-1:0]       digit_q [NUM_DIGITS];
  logic                   ssd_en_q, blink_phase_q, blink_wrap, wr, rd;
  logic [5:0]             off;
  logic                   unused;
  assign off        = sys_addr[7:2];
  assign unused     = ^{sys_addr[31:8], sys_addr[1:0]};
  assign wr         = sys_en && sys_wr_en;
  assign rd         = sys_en && !sys_wr_en;
  assign blink_wrap = blink_cnt_q >= blink_div_q;
  always_comb begin
    rd_d = off == SYSCTL_LED       ? WORD_W'(led_q)       :
           off == SYSCTL_BLINK     ? WORD_W'(blink_q)     :
           off == SYSCTL_BLINK_DIV ? WORD_W'(blink_div_q) :
           off == SYSCTL_SSD_CTRL  ? WORD_W'(ssd_en_q)    :
           off == SYSCTL_SSD_DIV   ? WORD_W'(ssd_div_q)   :
           off == SYSCTL_CYCLE     ? cycle_q              : '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (off == SYSCTL_DIGIT_BASE + 6'(i)) rd_d = WORD_W'(digit_q[i]);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      led_q         <= '0;
      blink_q       <= '0;
      blink_div_q   <= BLINK_DIV_RST;
      ssd_en_q      <= 1'b0;
      ssd_div_q     <= SCAN_DIV_RST;
      cycle_q       <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      led           <= '0;
      sys_rd_data   <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) digit_q[i] <= '0;
    end else begin
      if (wr && off == SYSCTL_LED)       led_q       <= sys_wr_data[NUM_LEDS-1:0];
      if (wr && off == SYSCTL_BLINK)     blink_q     <= sys_wr_data[NUM_LEDS-1:0];
      if (wr && off == SYSCTL_BLINK_DIV) blink_div_q <= sys_wr_data[BLINK_DIV_W-1:0];
      if (wr && off == SYSCTL_SSD_CTRL)  ssd_en_q    <= sys_wr_data[0];
      if (wr && off == SYSCTL_SSD_DIV)   ssd_div_q   <= sys_wr_data[SSD_DIV_W-1:0];
      for (int i = 0; i < NUM_DIGITS; i++)
        if (wr && off == SYSCTL_DIGIT_BASE + 6'(i)) digit_q[i] <= sys_wr_data[SEG_W-1:0];
      cycle_q       <= wr && off == SYSCTL_CYCLE ? sys_wr_data : cycle_q + 1'b1;
      blink_cnt_q   <= blink_wrap ? '0 : blink_cnt_q + 1'b1;
      blink_phase_q <= blink_phase_q ^ blink_wrap;
      led           <= led_q ^ (blink_q & {NUM_LEDS{blink_phase_q}});
      if (rd) sys_rd_data <= rd_d;
    end
  end
  snowflake_ssd_scan #(.NUM_DIGITS(NUM_DIGITS)) u_scan (
    .clk    (clk),
    .rst    (rst),
    .en     (ssd_en_q),
    .div    (ssd_div_q),
    .digits (digit_q),
    .seg    (ssd_seg),
    .sel    (ssd_sel)
  );
endmodule

// File: tb/tb_snowflake_sysctl.sv
// tb_snowflake_sysctl: directed test-plan scenarios plus random bus traffic against a register-map model
module tb_snowflake_sysctl;
  localparam int NL = 2;
  localparam int ND = 4;
  logic          clk = 1'b0, rst = 1'b1, sys_en = 1'b0, sys_wr_en = 1'b0;
  logic [31:0]   sys_addr = '0, sys_wr_data = '0, sys_rd_data;
  logic [NL-1:0] led;
  logic [6:0]    ssd_seg;
  logic [ND-1:0] ssd_sel;
  int n_checks = 0, n_errors = 0;
  always #5 clk = ~clk;
  snowflake_sysctl #(.NUM_LEDS(NL), .NUM_DIGITS(ND)) dut (
    .clk(clk), .rst(rst), .sys_addr(sys_addr), .sys_wr_data(sys_wr_data),
    .sys_en(sys_en), .sys_wr_en(sys_wr_en), .sys_rd_data(sys_rd_data),
    .led(led), .ssd_seg(ssd_seg), .ssd_sel(ssd_sel)
  );
  // model: register file as an offset-indexed array, counters as plain integers
  int unsigned m_reg [6];
  int unsigned m_dig [ND];
  int unsigned bcnt, scnt, idx, e_led, e_sel, e_seg, e_rd;
  bit          phase;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int unsigned fmask(int o);
    return o == 0 || o == 1 ? (1 << NL) - 1 : o == 2 ? 32'hFF_FFFF : o == 3 ? 1 : o == 4 ? 32'hFFFF : 32'hFFFF_FFFF;
  endfunction
  function automatic int unsigned mread(int o);
    return o < 6 ? m_reg[o] : (o >= 8 && o < 8 + ND) ? m_dig[o-8] : 0;
  endfunction
  task automatic model_step();
    int o;
    o = int'(sys_addr[7:2]);
    if (rst) begin
      m_reg = '{0, 0, 11999999, 0, 11999, 0};
      foreach (m_dig[i]) m_dig[i] = 0;
      {bcnt, scnt, idx, phase, e_led, e_sel, e_seg, e_rd} = '0;
      return;
    end
    e_led = (m_reg[0] ^ (phase ? m_reg[1] : 0)) & fmask(0);
    e_sel = m_reg[3] != 0 ? 1 << idx : 0;
    e_seg = m_reg[3] != 0 ? m_dig[idx] : 0;
    if (sys_en && !sys_wr_en) e_rd = mread(o);
    if (bcnt >= m_reg[2]) begin bcnt = 0; phase = !phase; end else bcnt++;
    if (m_reg[3] == 0) begin scnt = 0; idx = 0; end
    else if (scnt >= m_reg[4]) begin scnt = 0; idx = (idx + 1) % ND; end
    else scnt++;
    m_reg[5]++;
    if (sys_en && sys_wr_en) begin
      if (o < 6) m_reg[o] = sys_wr_data & fmask(o);
      else if (o >= 8 && o < 8 + ND) m_dig[o-8] = sys_wr_data & 32'h7F;
    end
  endtask
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("led", 32'(led), e_led);
    check("ssd_sel", 32'(ssd_sel), e_sel);
    check("ssd_seg", 32'(ssd_seg), e_seg);
    check("rd_data", sys_rd_data, e_rd);
  endtask
  task automatic wr(input int o, input logic [31:0] d);
    sys_en = 1; sys_wr_en = 1; sys_addr = 32'(o) << 2; sys_wr_data = d;
    tick();
    sys_en = 0; sys_wr_en = 0;
  endtask
  task automatic rd(input int o, output logic [31:0] d);
    sys_en = 1; sys_wr_en = 0; sys_addr = 32'(o) << 2;
    tick();
    d = sys_rd_data;
    sys_en = 0;
  endtask
  initial begin
    logic [31:0] v;
    int r;
    tick(); tick();
    rst = 0;
    rd(0, v);  check("rst_led_reg", v, 0);
    rd(4, v);  check("rst_ssd_div", v, 11999);
    rd(2, v);  check("rst_blink_div", v, 11999999);
    rd(63, v); check("rst_off3f", v, 0);
    check("rst_led_out", 32'(led), 0);
    check("rst_sel_out", 32'(ssd_sel), 0);
    // scan stepping with a 4-cycle period per digit
    wr(8, 32'h3F); wr(9, 32'h06); wr(10, 32'h5B); wr(11, 32'h4F);
    wr(4, 3); wr(3, 1);
    for (int k = 0; k < 20; k++) begin
      logic [31:0] segs [4];
      segs = '{32'h3F, 32'h06, 32'h5B, 32'h4F};
      tick();
      check("scan_sel", 32'(ssd_sel), 32'(1) << ((k / 4) % 4));
      check("scan_seg", 32'(ssd_seg), segs[(k / 4) % 4]);
    end
    wr(3, 0);
    tick();
    check("dis_sel", 32'(ssd_sel), 0);
    check("dis_seg", 32'(ssd_seg), 0);
    // blink alternation, then steady once the mask clears
    wr(0, 1); wr(1, 3); wr(2, 2);
    repeat (12) tick();
    wr(1, 0);
    tick();
    for (int k = 0; k < 6; k++) begin tick(); check("steady_led", 32'(led), 1); end
    // cycle counter wrap seen through back-to-back reads
    wr(5, 32'hFFFF_FFFE);
    for (int k = 0; k < 4; k++) begin rd(5, v); check("cycle_wrap", v, 32'hFFFF_FFFE + 32'(k)); end
    // shrink the scan divider mid-count
    wr(4, 100); wr(3, 1);
    for (int i = 0; i < 200 && scnt != 10; i++) tick();
    check("scnt_reach_10", scnt, 10);
    wr(4, 5);
    tick(); check("mid_sel0", 32'(ssd_sel), 1);
    tick(); check("mid_sel1", 32'(ssd_sel), 2);
    repeat (5) tick();
    rst = 1; tick(); rst = 0;
    check("prst_led", 32'(led), 0);
    check("prst_sel", 32'(ssd_sel), 0);
    check("prst_seg", 32'(ssd_seg), 0);
    rd(4, v); check("prst_ssd_div", v, 11999);
    // unmapped and out-of-range digit writes are dropped
    wr(0, 2);
    wr(8 + ND, 32'hFFFF_FFFF); wr(7, 32'hFFFF_FFFF);
    rd(8 + ND, v); check("oor_digit", v, 0);
    rd(7, v);      check("off07", v, 0);
    rd(0, v);      check("led_kept", v, 2);
    // random traffic with short dividers so wraps happen often
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 15);
      sys_addr    = 32'(r == 13 ? 63 : r) << 2 | 32'($urandom_range(0, 3));
      sys_en      = $urandom_range(0, 2) != 0;
      sys_wr_en   = $urandom_range(0, 1) == 1;
      sys_wr_data = (r == 2 || r == 4) && $urandom_range(0, 7) != 0 ? 32'($urandom_range(0, 9)) : $urandom;
      rst         = $urandom_range(0, 499) == 0;
      tick();
    end
    sys_en = 0; rst = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
